// File: rtl/csi_tx_pkg.sv
// rtl/csi_tx_pkg.sv - shared types, D-PHY timing defaults and lane-drive decode for the CSI-2 TX clock lane
package csi_tx_pkg;

  // Nine states need four bits; encodings 9..15 are illegal.
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_LP01     = 4'd1,
    ST_LP00     = 4'd2,
    ST_HS_ZERO  = 4'd3,
    ST_HS_PRE   = 4'd4,
    ST_HS_RUN   = 4'd5,
    ST_HS_POST  = 4'd6,
    ST_HS_TRAIL = 4'd7,
    ST_HS_EXIT  = 4'd8
  } lane_state_t;

  localparam int unsigned DEF_T_LPX       = 4;
  localparam int unsigned DEF_T_CLK_ZERO  = 16;
  localparam int unsigned DEF_T_CLK_PRE   = 2;
  localparam int unsigned DEF_T_CLK_POST  = 8;
  localparam int unsigned DEF_T_CLK_TRAIL = 4;
  localparam int unsigned DEF_T_HS_EXIT   = 8;

  // LP line states as {Dp, Dn}
  localparam logic [1:0] LP11 = 2'b11;
  localparam logic [1:0] LP01 = 2'b01;
  localparam logic [1:0] LP00 = 2'b00;

  typedef struct packed {
    logic [1:0] lp;
    logic       hs_oe;
    logic       hs_clk_en;
    logic       clk_ready;
    logic       busy;
  } lane_drive_t;

  localparam lane_drive_t DRIVE_RESET = {LP11, 4'b0000};

  function automatic logic [7:0] timer_load(input int unsigned cycles);
    return 8'(cycles - 1);
  endfunction

  // LP drivers sit at LP-00 whenever the HS driver owns the lane.
  function automatic lane_drive_t drive_for(input lane_state_t s);
    lane_drive_t d;
    d.lp        = LP00;
    d.hs_oe     = 1'b0;
    d.hs_clk_en = 1'b0;
    d.clk_ready = 1'b0;
    case (s)
      ST_IDLE:     d.lp = LP11;
      ST_LP01:     d.lp = LP01;
      ST_LP00:     d.lp = LP00;
      ST_HS_ZERO:  d.hs_oe = 1'b1;
      ST_HS_PRE: begin
        d.hs_oe     = 1'b1;
        d.hs_clk_en = 1'b1;
      end
      ST_HS_RUN: begin
        d.hs_oe     = 1'b1;
        d.hs_clk_en = 1'b1;
        d.clk_ready = 1'b1;
      end
      ST_HS_POST: begin
        d.hs_oe     = 1'b1;
        d.hs_clk_en = 1'b1;
      end
      ST_HS_TRAIL: d.hs_oe = 1'b1;
      default:     d.lp = LP11;
    endcase
    d.busy = (s != ST_IDLE);
    return d;
  endfunction

endpackage

// File: rtl/csi_tx_clk_lane_ctrl_if.sv
// rtl/csi_tx_clk_lane_ctrl_if.sv - request/status and line-drive bundle of the TX clock lane
interface csi_tx_clk_lane_ctrl_if;

  logic hs_req;
  logic data_busy;
  logic lp_p;
  logic lp_n;
  logic hs_oe;
  logic hs_clk_en;
  logic clk_ready;
  logic busy;

  modport master (
    input  hs_req,
    input  data_busy,
    output lp_p,
    output lp_n,
    output hs_oe,
    output hs_clk_en,
    output clk_ready,
    output busy
  );

  modport slave (
    output hs_req,
    output data_busy,
    input  lp_p,
    input  lp_n,
    input  hs_oe,
    input  hs_clk_en,
    input  clk_ready,
    input  busy
  );

endinterface

// File: rtl/csi_tx_clk_lane_ctrl.sv
// rtl/csi_tx_clk_lane_ctrl.sv - D-PHY clock-lane sequencer (LP-11 -> HS clock -> trail -> LP-11); CSI_TX_CLK_CONTINUOUS_EN pins the lane in HS once running
module csi_tx_clk_lane_ctrl
  import csi_tx_pkg::*;
#(
  parameter int unsigned T_LPX       = DEF_T_LPX,
  parameter int unsigned T_CLK_ZERO  = DEF_T_CLK_ZERO,
  parameter int unsigned T_CLK_PRE   = DEF_T_CLK_PRE,
  parameter int unsigned T_CLK_POST  = DEF_T_CLK_POST,
  parameter int unsigned T_CLK_TRAIL = DEF_T_CLK_TRAIL,
  parameter int unsigned T_HS_EXIT   = DEF_T_HS_EXIT
) (
  input logic                    byte_clock,
  input logic                    reset_in,
  csi_tx_clk_lane_ctrl_if.master lane
);

  lane_state_t state;
  lane_state_t state_next;
  logic [7:0]  timer;
  logic [7:0]  timer_next;
  logic        timer_done;
  lane_drive_t drive_q;
  lane_drive_t drive_next;

  assign timer_done = (timer == 8'd0);

  function automatic logic [7:0] state_timer_load(input lane_state_t s);
    case (s)
      ST_LP01, ST_LP00: return timer_load(T_LPX);
      ST_HS_ZERO:       return timer_load(T_CLK_ZERO);
      ST_HS_PRE:        return timer_load(T_CLK_PRE);
      ST_HS_POST:       return timer_load(T_CLK_POST);
      ST_HS_TRAIL:      return timer_load(T_CLK_TRAIL);
      ST_HS_EXIT:       return timer_load(T_HS_EXIT);
      default:          return 8'd0;
    endcase
  endfunction

  always_ff @(posedge byte_clock or posedge reset_in) begin
    if (reset_in) begin
      state   <= ST_IDLE;
      timer   <= 8'd0;
      drive_q <= DRIVE_RESET;
    end else begin
      state   <= state_next;
      timer   <= timer_next;
      drive_q <= drive_next;
    end
  end

  // Startup is never aborted: once out of IDLE the lane only returns through HS_RUN.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (lane.hs_req) state_next = ST_LP01;
      ST_LP01:     if (timer_done) state_next = ST_LP00;
      ST_LP00:     if (timer_done) state_next = ST_HS_ZERO;
      ST_HS_ZERO:  if (timer_done) state_next = ST_HS_PRE;
      ST_HS_PRE:   if (timer_done) state_next = ST_HS_RUN;
      ST_HS_RUN: begin
`ifndef CSI_TX_CLK_CONTINUOUS_EN
        if (!lane.hs_req && !lane.data_busy) state_next = ST_HS_POST;
`endif
      end
      ST_HS_POST: begin
        if (lane.hs_req)     state_next = ST_HS_RUN;
        else if (timer_done) state_next = ST_HS_TRAIL;
      end
      ST_HS_TRAIL: if (timer_done) state_next = ST_HS_EXIT;
      ST_HS_EXIT:  if (timer_done) state_next = ST_IDLE;
      default:     state_next = ST_HS_EXIT;
    endcase
  end

  always_comb begin
    timer_next = timer;
    if (state_next != state) begin
      timer_next = state_timer_load(state_next);
    end else if (!timer_done) begin
      timer_next = timer - 8'd1;
    end
  end

  always_comb begin
    drive_next = drive_for(state_next);
  end

  assign lane.lp_p      = drive_q.lp[1];
  assign lane.lp_n      = drive_q.lp[0];
  assign lane.hs_oe     = drive_q.hs_oe;
  assign lane.hs_clk_en = drive_q.hs_clk_en;
  assign lane.clk_ready = drive_q.clk_ready;
  assign lane.busy      = drive_q.busy;

endmodule

// File: tb/tb_csi_tx_clk_lane_ctrl.sv
// tb/tb_csi_tx_clk_lane_ctrl.sv - directed bench with a phase/elapsed-time lane model for csi_tx_clk_lane_ctrl
module tb_csi_tx_clk_lane_ctrl;

  localparam int T_LPX       = 4;
  localparam int T_CLK_ZERO  = 16;
  localparam int T_CLK_PRE   = 2;
  localparam int T_CLK_POST  = 8;
  localparam int T_CLK_TRAIL = 4;
  localparam int T_HS_EXIT   = 8;

  localparam int P_IDLE = 0, P_LP01 = 1, P_LP00 = 2, P_ZERO = 3, P_PRE = 4,
                 P_RUN = 5, P_POST = 6, P_TRAIL = 7, P_EXIT = 8;

  logic byte_clock = 1'b0;
  logic reset_in;
  int   checks = 0;
  int   errors = 0;

  csi_tx_clk_lane_ctrl_if lane_if ();

  csi_tx_clk_lane_ctrl #(
    .T_LPX(T_LPX), .T_CLK_ZERO(T_CLK_ZERO), .T_CLK_PRE(T_CLK_PRE),
    .T_CLK_POST(T_CLK_POST), .T_CLK_TRAIL(T_CLK_TRAIL), .T_HS_EXIT(T_HS_EXIT)
  ) dut (
    .byte_clock(byte_clock),
    .reset_in(reset_in),
    .lane(lane_if)
  );

  always #5 byte_clock = ~byte_clock;

  // Lane model: phase plus cycles spent in it; phases run in timeline order.
  int m_phase = P_IDLE;
  int m_elapsed = 0;

  function automatic int dur(input int ph);
    case (ph)
      P_LP01, P_LP00: return T_LPX;
      P_ZERO:         return T_CLK_ZERO;
      P_PRE:          return T_CLK_PRE;
      P_POST:         return T_CLK_POST;
      P_TRAIL:        return T_CLK_TRAIL;
      P_EXIT:         return T_HS_EXIT;
      default:        return 0;
    endcase
  endfunction

  function automatic logic [5:0] exp_vec(input int ph);
    logic lp11, lp_n, oe, en, rdy, bsy;
    lp11 = (ph == P_IDLE) || (ph == P_EXIT);
    lp_n = lp11 || (ph == P_LP01);
    oe   = (ph >= P_ZERO) && (ph <= P_TRAIL);
    en   = (ph == P_PRE) || (ph == P_RUN) || (ph == P_POST);
    rdy  = (ph == P_RUN);
    bsy  = (ph != P_IDLE);
    return {lp11, lp_n, oe, en, rdy, bsy};
  endfunction

  always @(posedge byte_clock or posedge reset_in) begin
    int nxt;
    if (reset_in) begin
      m_phase   = P_IDLE;
      m_elapsed = 0;
    end else begin
      nxt = m_phase;
      case (m_phase)
        P_IDLE: if (lane_if.hs_req) nxt = P_LP01;
        P_RUN: begin
`ifndef CSI_TX_CLK_CONTINUOUS_EN
          if (!lane_if.hs_req && !lane_if.data_busy) nxt = P_POST;
`endif
        end
        P_POST: begin
          if (lane_if.hs_req) nxt = P_RUN;
          else if (m_elapsed == dur(P_POST)) nxt = P_TRAIL;
        end
        P_EXIT: if (m_elapsed == dur(P_EXIT)) nxt = P_IDLE;
        default: if (m_elapsed == dur(m_phase)) nxt = m_phase + 1;
      endcase
      m_elapsed = (nxt != m_phase) ? 1 : m_elapsed + 1;
      m_phase   = nxt;
    end
  end

  always @(negedge byte_clock) begin
    logic [5:0] got;
    logic [5:0] want;
    got  = {lane_if.lp_p, lane_if.lp_n, lane_if.hs_oe, lane_if.hs_clk_en,
            lane_if.clk_ready, lane_if.busy};
    want = exp_vec(m_phase);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL model_compare t=%0t phase=%0d got %b want %b", $time, m_phase, got, want);
    end
  end

  task automatic tick();
    @(negedge byte_clock);
  endtask

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!lane_if.clk_ready && n <= 80);
  endtask

  task automatic run_stop(output int rdy_n, output int post_n, output int trail_n, output int exit_n);
    int n;
    rdy_n = 0; post_n = 0; trail_n = 0; exit_n = 0; n = 0;
    forever begin
      tick();
      n++;
      if (!lane_if.busy || n > 60) break;
      if (lane_if.clk_ready) rdy_n++;
      else if (lane_if.hs_clk_en) post_n++;
      else if (lane_if.hs_oe) trail_n++;
      else exit_n++;
    end
  endtask

  initial begin
    int n, first_lp01, first_lp00, first_oe, first_en, cnt, oe_low;
    int r, p, t, x;
    reset_in = 1'b1;
    lane_if.hs_req = 1'b0;
    lane_if.data_busy = 1'b0;
    repeat (3) tick();
    reset_in = 1'b0;

    // 1: idle with no request
    for (int i = 0; i < 20; i++) begin
      tick();
      check("s1_idle_lines", {lane_if.lp_p, lane_if.lp_n, lane_if.hs_oe, lane_if.busy}, 4'b1100);
    end

    // 2: startup timeline
    lane_if.hs_req = 1'b1;
    n = 0; first_lp01 = 0; first_lp00 = 0; first_oe = 0; first_en = 0;
    do begin
      tick();
      n++;
      if (first_lp01 == 0 && !lane_if.lp_p && lane_if.lp_n) first_lp01 = n;
      if (first_lp00 == 0 && !lane_if.lp_p && !lane_if.lp_n) first_lp00 = n;
      if (first_oe == 0 && lane_if.hs_oe) first_oe = n;
      if (first_en == 0 && lane_if.hs_clk_en) first_en = n;
    end while (!lane_if.clk_ready && n <= 80);
    check("s2_first_lp01", first_lp01, 1);
    check("s2_first_lp00", first_lp00, 5);
    check("s2_first_hs_oe", first_oe, 9);
    check("s2_first_clk_en", first_en, 25);
    check("s2_ready_latency", n, 27);

    // 3: data_busy holds HS_RUN, then the full stop sequence
    lane_if.hs_req = 1'b0;
    lane_if.data_busy = 1'b1;
    cnt = 0;
    repeat (10) begin
      tick();
      cnt += int'(lane_if.clk_ready);
    end
    check("s3_held_by_busy", cnt, 10);
    lane_if.data_busy = 1'b0;
`ifndef CSI_TX_CLK_CONTINUOUS_EN
    run_stop(r, p, t, x);
    check("s3_extra_ready", r, 0);
    check("s3_post_len", p, 8);
    check("s3_trail_len", t, 4);
    check("s3_exit_len", x, 8);
    check("s3_back_idle", int'(lane_if.busy), 0);

    // 4: one-cycle request pulse in LP00 still completes startup then stops
    lane_if.hs_req = 1'b1;
    tick();
    lane_if.hs_req = 1'b0;
    repeat (4) tick();
    check("s4_in_lp00", {lane_if.lp_p, lane_if.lp_n, lane_if.hs_oe}, 3'b000);
    lane_if.hs_req = 1'b1;
    tick();
    lane_if.hs_req = 1'b0;
    n = 6; cnt = 0;
    do begin
      tick();
      n++;
      if (lane_if.lp_p && lane_if.lp_n) cnt++;
    end while (!lane_if.clk_ready && n <= 80);
    check("s4_ready_latency", n, 27);
    check("s4_no_early_lp11", cnt, 0);
    run_stop(r, p, t, x);
    check("s4_ready_width_extra", r, 0);
    check("s4_stop_total", p + t + x, 20);

    // 5: request returns during the 3rd HS_POST cycle
    lane_if.hs_req = 1'b1;
    wait_ready(n);
    check("s5_ready_latency", n, 27);
    lane_if.hs_req = 1'b0;
    oe_low = 0;
    repeat (3) begin
      tick();
      if (!lane_if.hs_oe) oe_low++;
    end
    check("s5_in_post", {lane_if.hs_clk_en, lane_if.clk_ready}, 2'b10);
    lane_if.hs_req = 1'b1;
    tick();
    check("s5_back_to_run", int'(lane_if.clk_ready), 1);
    repeat (5) begin
      tick();
      if (!lane_if.hs_oe) oe_low++;
    end
    check("s5_hs_oe_never_low", oe_low, 0);
    lane_if.hs_req = 1'b0;
    run_stop(r, p, t, x);
    check("s5_post_len", p, 8);
    check("s5_stop_total", r + p + t + x, 20);
`else
    cnt = 0;
    repeat (40) begin
      tick();
      cnt += int'(lane_if.clk_ready && lane_if.hs_oe);
    end
    check("s3c_stays_run", cnt, 40);
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
    repeat (2) tick();
`endif

    // 6: asynchronous reset in HS_PRE
    lane_if.hs_req = 1'b1;
    repeat (25) tick();
    check("s6_in_pre", {lane_if.hs_oe, lane_if.hs_clk_en, lane_if.clk_ready}, 3'b110);
    #2;
    reset_in = 1'b1;
    lane_if.hs_req = 1'b0;
    #1;
    check("s6_reset_lines", {lane_if.lp_p, lane_if.lp_n, lane_if.hs_oe, lane_if.hs_clk_en}, 4'b1100);
    tick();
    reset_in = 1'b0;
    repeat (5) tick();
    check("s6_idle_after", {lane_if.lp_p, lane_if.lp_n, lane_if.busy}, 3'b110);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
